// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and helpers for the pipe_reg_chain register chain.
package pipe_pkg;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_STAGES    = 2;
    localparam int DEF_RESET_VAL = 0;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register; bubbles advance the valid bit but leave data untouched.
module pipe_stage import pipe_pkg::*; #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
            if (in_valid)
                data <= in_data;
        end
    end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic STAGES-deep valid/ready register chain with synchronous flush.
// Define PIPE_REG_CHAIN_OCC_EN to add the registered occupancy output.
module pipe_reg_chain import pipe_pkg::*; #(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STAGES    = DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    output logic [occ_width(STAGES)-1:0]    occupancy
`endif
);
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] ready;
    logic [WIDTH-1:0]  data [STAGES];

    // A stage can load when it is empty or everything downstream can move.
    always_comb begin
        logic r;
        r     = out_ready;
        ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r        = !valid[k] || r;
            ready[k] = r;
        end
    end

    assign in_ready  = ready[0] && !flush && !reset;
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .load     (ready[i]),
                .in_valid (in_valid && in_ready),
                .in_data  (in_data),
                .valid    (valid[i]),
                .data     (data[i])
            );
        end else begin : g_body
            pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .load     (ready[i]),
                .in_valid (valid[i-1]),
                .in_data  (data[i-1]),
                .valid    (valid[i]),
                .data     (data[i])
            );
        end
    end

`ifdef PIPE_REG_CHAIN_OCC_EN
    localparam int OW = occ_width(STAGES);

    // Tracking transfers keeps occupancy equal to popcount(valid) without an adder tree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occupancy <= '0;
        else if (flush)
            occupancy <= '0;
        else
            occupancy <= occupancy + OW'(in_valid && in_ready) - OW'(out_valid && out_ready);
    end
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and random scoreboard checks on an 8-bit/2-stage and a 32-bit/4-stage chain.
module tb_pipe_reg_chain;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       f8, iv8, ir8, ov8, or8;
    logic [7:0] id8, od8;
    logic        f32, iv32, ir32, ov32, or32;
    logic [31:0] id32, od32;
`ifdef PIPE_REG_CHAIN_OCC_EN
    logic [1:0] occ8;
    logic [2:0] occ32;
`endif

    pipe_reg_chain u_d8 (
        .clk(clk), .reset(reset), .flush(f8),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8)
`ifdef PIPE_REG_CHAIN_OCC_EN
        , .occupancy(occ8)
`endif
    );

    pipe_reg_chain #(.WIDTH(32), .STAGES(4), .RESET_VAL(32'hDEADBEEF)) u_d32 (
        .clk(clk), .reset(reset), .flush(f32),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32)
`ifdef PIPE_REG_CHAIN_OCC_EN
        , .occupancy(occ32)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit lat_on = 1'b0;
    logic [7:0]  q8[$];
    int          t8[$];
    logic [31:0] q32[$];
    int          t32[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the 8-bit chain; exp_ir < 0 skips the in_ready check.
    task automatic cyc8(input logic v, input logic [7:0] d, input logic ordy, input logic fl, input int exp_ir);
        int lat;
        iv8 = v; id8 = d; or8 = ordy; f8 = fl;
        #1;
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("d8_occ", 32'(occ8), 32'(q8.size()));
`endif
        if (exp_ir >= 0) chk("d8_in_ready", 32'(ir8), 32'(exp_ir));
        if (ov8 && or8) begin
            if (q8.size() == 0) chk("d8_unexpected_out", 32'(ov8), 32'(0));
            else begin
                chk("d8_out", 32'(od8), 32'(q8.pop_front()));
                lat = t8.pop_front();
                if (lat_on) chk("d8_latency", 32'(cyc - lat), 32'(2));
            end
        end
        if (v && ir8) begin q8.push_back(d); t8.push_back(cyc); end
        if (fl) begin q8.delete(); t8.delete(); end
        @(negedge clk);
    endtask

    task automatic cyc32(input logic v, input logic [31:0] d, input logic ordy, input logic fl, input int exp_ir);
        int lat;
        iv32 = v; id32 = d; or32 = ordy; f32 = fl;
        #1;
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("d32_occ", 32'(occ32), 32'(q32.size()));
`endif
        if (exp_ir >= 0) chk("d32_in_ready", 32'(ir32), 32'(exp_ir));
        if (ov32 && or32) begin
            if (q32.size() == 0) chk("d32_unexpected_out", 32'(ov32), 32'(0));
            else begin
                chk("d32_out", od32, q32.pop_front());
                lat = t32.pop_front();
                if (lat_on) chk("d32_latency", 32'(cyc - lat), 32'(4));
            end
        end
        if (v && ir32) begin q32.push_back(d); t32.push_back(cyc); end
        if (fl) begin q32.delete(); t32.delete(); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        f8 = 0; iv8 = 0; or8 = 0; id8 = '0;
        f32 = 0; iv32 = 0; or32 = 0; id32 = '0;
        #1;
        chk("rst_d8_in_ready", 32'(ir8), 32'(0));
        chk("rst_d8_out_valid", 32'(ov8), 32'(0));
        chk("rst_d8_out_data", 32'(od8), 32'h00);
        chk("rst_d32_out_data", od32, 32'hDEADBEEF);
        chk("rst_d32_in_ready", 32'(ir32), 32'(0));
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("rst_d8_occ", 32'(occ8), 32'(0));
`endif
        @(negedge clk);
        reset = 1'b0;

        // Streaming at full rate
        lat_on = 1'b1;
        cyc8(1, 8'h11, 1, 0, 1);
        cyc8(1, 8'h22, 1, 0, 1);
        cyc8(1, 8'h33, 1, 0, 1);
        repeat (3) cyc8(0, 8'h00, 1, 0, 1);
        lat_on = 1'b0;
        chk("d8_stream_drained", 32'(q8.size()), 32'(0));

        // Backpressure
        cyc8(1, 8'hA1, 0, 0, 1);
        cyc8(1, 8'hA2, 0, 0, 1);
        chk("bp_out_valid", 32'(ov8), 32'(1));
        chk("bp_out_data", 32'(od8), 32'hA1);
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("bp_occ_full", 32'(occ8), 32'(2));
`endif
        cyc8(1, 8'hA3, 0, 0, 0);
        chk("bp_out_held", 32'(od8), 32'hA1);
        cyc8(1, 8'hA3, 1, 0, 1);
        repeat (4) cyc8(0, 8'h00, 1, 0, 1);
        chk("bp_drained", 32'(q8.size()), 32'(0));

        // Hole compression while output stalled
        cyc8(1, 8'h55, 0, 0, 1);
        cyc8(0, 8'h00, 0, 0, 1);
        chk("hole_out_valid", 32'(ov8), 32'(1));
        chk("hole_out_data", 32'(od8), 32'h55);
        chk("hole_in_ready", 32'(ir8), 32'(1));
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("hole_occ", 32'(occ8), 32'(1));
`endif
        repeat (3) cyc8(0, 8'h00, 1, 0, 1);

        // Flush with a simultaneous input
        cyc8(1, 8'h01, 0, 0, 1);
        cyc8(1, 8'h02, 0, 0, 1);
        cyc8(1, 8'h03, 0, 1, 0);
        chk("flush_out_valid", 32'(ov8), 32'(0));
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("flush_occ", 32'(occ8), 32'(0));
`endif
        repeat (4) cyc8(0, 8'h00, 1, 0, 1);

        // Asynchronous reset mid-stream
        cyc8(1, 8'h77, 1, 0, 1);
        cyc8(1, 8'h78, 1, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(ov8), 32'(0));
        chk("mid_rst_in_ready", 32'(ir8), 32'(0));
        chk("mid_rst_out_data", 32'(od8), 32'h00);
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("mid_rst_occ", 32'(occ8), 32'(0));
`endif
        q8.delete(); t8.delete();
        @(negedge clk);
        reset = 1'b0;
        lat_on = 1'b1;
        cyc8(1, 8'h99, 1, 0, 1);
        repeat (3) cyc8(0, 8'h00, 1, 0, 1);
        lat_on = 1'b0;
        chk("post_rst_drained", 32'(q8.size()), 32'(0));

        // Wide/deep chain: zero-stall latency, then random handshakes
        lat_on = 1'b1;
        for (int i = 0; i < 5; i++) cyc32(1, $urandom, 1, 0, 1);
        repeat (6) cyc32(0, 32'h0, 1, 0, 1);
        lat_on = 1'b0;
        chk("d32_stream_drained", 32'(q32.size()), 32'(0));
        repeat (300) cyc32(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0, 0, -1);
        repeat (12) cyc32(0, 32'h0, 1, 0, -1);
        chk("d32_random_drained", 32'(q32.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised elastic pipeline register chain; successor to the fixed 8-bit D register used in datapath stages.
- Carries WIDTH-bit data through STAGES registered stages.
- Each stage has a valid bit; valid/ready handshake on both ends; synchronous flush.
- Sits between datapath stages (e.g. ALU result to writeback) where stalls and pipeline flushes are required.

Parameters:
WIDTH, 8, data width in bits (>=1)
STAGES, 2, number of register stages (>=1); zero-stall latency in cycles
RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline clear
in_valid  input  1  upstream data valid
in_ready  output  1  chain can accept in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  last stage data
occupancy  output  $clog2(STAGES+1)  number of valid stages (only with PIPE_REG_CHAIN_OCC_EN)

Behaviour:
- Reset: reset (asynchronous, active-high), clock clk. While reset is high, all valid[i]=0 and all data[i]=RESET_VAL. Outputs: out_valid=0, out_data=RESET_VAL, occupancy=0. in_ready=0 while reset is high.
- Stage indices: 0 = input side, STAGES-1 = output side.
- Per-stage ready (combinational chain):
  - ready[STAGES-1] = !valid[STAGES-1] || out_ready
  - ready[i] = !valid[i] || ready[i+1]
  - in_ready = ready[0] && !flush && !reset
- Stage i load condition: ready[i]. On load:
  - stage 0 takes data[0] <= in_data, valid[0] <= in_valid && in_ready
  - stage i>0 takes data[i] <= data[i-1], valid[i] <= valid[i-1]
- Data registers load only when the incoming valid is 1; bubbles do not overwrite data.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Throughput: one item per cycle while out_ready=1. No bubble insertion. Full chain with out_ready=1 accepts and emits in the same cycle.
- Latency: an item accepted at edge N appears on out_valid after edge N+STAGES-1 (visible in cycle N+STAGES) if no stall.
- Stall: out_ready=0 with the chain full gives in_ready=0. Holes are compressed: a valid stage advances into an empty downstream stage even while the output is stalled.
- Ordering: strictly FIFO. No item is dropped or duplicated except by flush.
- flush=1 at an edge:
  - all valid[i] <= 0; data registers unchanged
  - in_ready=0 that cycle, so no input is accepted
  - out_valid still reflects the pre-flush state that cycle; an output transfer in that cycle counts as delivered
- Flush has priority over every load. Simultaneous flush with in_valid=1 means the item is not accepted.
- Reset mid-operation: immediate asynchronous clear as above; data is lost; the first edge after deassertion behaves as an empty chain.
- No combinational path from in_data to out_data.
- Combinational paths are limited to out_ready -> in_ready, through the ready chain.

Optional Feature:
Macro PIPE_REG_CHAIN_OCC_EN.
- Defined: occupancy port exists and equals the popcount of valid[STAGES-1:0], registered alongside valid (updates the same edge). Reset value 0; flush gives 0 the next cycle.
- Undefined: occupancy port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg: default WIDTH/STAGES constants, occupancy-width function (clog2 of STAGES+1), RESET_VAL default.
- One sub-module, pipe_stage: a single valid+data register with load/flush/reset. It is instantiated STAGES times in a generate loop; the ready chain stays in the top.

Test Plan:
- Reset/idle: reset high mid-stream with WIDTH=8, STAGES=2, RESET_VAL=0 -> out_valid=0, out_data=0x00, in_ready=0 while reset high; occupancy=0.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first accept; in_ready constantly 1.
- Backpressure: fill with 0xA1,0xA2 and hold out_ready=0 -> in_ready=0, occupancy=2, out_data=0xA1 held. Release out_ready for 1 cycle -> 0xA1 leaves, 0xA3 accepted the same cycle.
- Hole compression: push 0x55 alone, out_ready=0 -> 0x55 reaches the last stage after 2 edges, occupancy=1, in_ready=1.
- Flush: chain holding 0x01,0x02, assert flush with in_valid=1 in_data=0x03 -> next cycle out_valid=0, occupancy=0, 0x03 never emitted.
- Parametrisation: WIDTH=32, STAGES=4, RESET_VAL=0xDEADBEEF -> out_data=0xDEADBEEF after reset; random valid/ready scoreboard shows 4-cycle zero-stall latency and in-order, lossless delivery.
